// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types for the ssdram port arbiter: FSM states, port identifiers, default bus widths.
// Imported by the arbiter top, its priority picker and the port interface.
package sdram_arb_pkg;

    localparam int ARB_AW = 25;
    localparam int ARB_DW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_VID  = 2'd1,
        PORT_CPU  = 2'd2,
        PORT_IOC  = 2'd3
    } port_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of requester handshakes (video, CPU, ioctl) and the ssdram controller side.
// The arbiter uses the slave view; the surrounding top level (or a bench) uses the master view.
interface sdram_port_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
);
    logic          dl_active_i;

    logic          vid_req_i;
    logic [AW-1:0] vid_addr_i;
    logic          vid_ack_o;

    logic          cpu_req_i;
    logic          cpu_we_i;
    logic [AW-1:0] cpu_addr_i;
    logic [DW-1:0] cpu_wdata_i;
    logic          cpu_ack_o;

    logic          ioc_req_i;
    logic [AW-1:0] ioc_addr_i;
    logic [DW-1:0] ioc_wdata_i;
    logic          ioc_ack_o;

    logic [DW-1:0] rdata_o;

    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic          mem_cs_o;
    logic          mem_oe_o;
    logic          mem_we_o;
    logic [DW-1:0] mem_data_i;
    logic          mem_done_i;

    logic          err_o;

    modport slave (
        input  dl_active_i,
        input  vid_req_i, vid_addr_i,
        output vid_ack_o,
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output cpu_ack_o,
        input  ioc_req_i, ioc_addr_i, ioc_wdata_i,
        output ioc_ack_o,
        output rdata_o,
        output mem_addr_o, mem_data_o, mem_cs_o, mem_oe_o, mem_we_o,
        input  mem_data_i, mem_done_i,
        output err_o
    );

    modport master (
        output dl_active_i,
        output vid_req_i, vid_addr_i,
        input  vid_ack_o,
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_ack_o,
        output ioc_req_i, ioc_addr_i, ioc_wdata_i,
        input  ioc_ack_o,
        input  rdata_o,
        input  mem_addr_o, mem_data_o, mem_cs_o, mem_oe_o, mem_we_o,
        output mem_data_i, mem_done_i,
        input  err_o
    );

endinterface

// File: rtl/sdram_port_arbiter_prio.sv
// Combinational winner pick: video > CPU > ioctl, with ioctl forced to win once starved.
// Zero latency; requests are expected to be pre-masked by the caller.
module sdram_arb_prio
    import sdram_arb_pkg::*;
(
    input  logic  vid_req,
    input  logic  cpu_req,
    input  logic  ioc_req,
    input  logic  starve_hit,
    output port_t winner
);

    always_comb begin
        winner = PORT_NONE;
        if (starve_hit && ioc_req) begin
            winner = PORT_IOC;
        end else if (vid_req) begin
            winner = PORT_VID;
        end else if (cpu_req) begin
            winner = PORT_CPU;
        end else if (ioc_req) begin
            winner = PORT_IOC;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the single ssdram port between video, CPU and ioctl download; one transaction at a time.
// Strobes rise the cycle after a grant; the ack pulses the cycle after mem_done_i or a timeout abort.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int AW      = ARB_AW,
    parameter int DW      = ARB_DW,
    parameter int STARVE  = 16,
    parameter int TIMEOUT = 255
) (
    input logic                 clock_i,
    input logic                 reset_i,
    sdram_port_arbiter_if.slave bus
);

    localparam int SW = $clog2(STARVE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t    state;
    arb_state_t    state_nxt;
    port_t         grant;
    port_t         winner;

    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          lat_we;
    logic [DW-1:0] rdata;
    logic          err;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] to_cnt;

    logic          cpu_req_eff;
    logic          starve_hit;
    logic          to_hit;
    logic          do_grant;

    assign cpu_req_eff = bus.cpu_req_i & ~bus.dl_active_i;
    assign starve_hit  = (starve_cnt == SW'(STARVE));
    // to_cnt counts completed WAIT cycles, so TIMEOUT-1 marks the last allowed one
    assign to_hit      = (to_cnt == TW'(TIMEOUT - 1));

    sdram_arb_prio u_prio (
        .vid_req    (bus.vid_req_i),
        .cpu_req    (cpu_req_eff),
        .ioc_req    (bus.ioc_req_i),
        .starve_hit (starve_hit),
        .winner     (winner)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        case (state)
            IDLE: begin
                if (winner != PORT_NONE) begin
                    do_grant  = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_done_i || to_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            grant      <= PORT_NONE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
            starve_cnt <= '0;
            to_cnt     <= '0;
        end else begin
            if (do_grant) begin
                grant <= winner;
                case (winner)
                    PORT_VID: begin
                        lat_addr  <= bus.vid_addr_i;
                        lat_wdata <= '0;
                        lat_we    <= 1'b0;
                    end
                    PORT_CPU: begin
                        lat_addr  <= bus.cpu_addr_i;
                        lat_wdata <= bus.cpu_wdata_i;
                        lat_we    <= bus.cpu_we_i;
                    end
                    PORT_IOC: begin
                        lat_addr  <= bus.ioc_addr_i;
                        lat_wdata <= bus.ioc_wdata_i;
                        lat_we    <= 1'b1;
                    end
                    default: ;
                endcase

                if (winner == PORT_IOC) begin
                    starve_cnt <= '0;
                end else if (bus.ioc_req_i && !starve_hit) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end

            case (state)
                WAIT: begin
                    if (bus.mem_done_i) begin
                        if (!lat_we) begin
                            rdata <= bus.mem_data_i;
                        end
                    end else if (to_hit) begin
                        err   <= 1'b1;
                        rdata <= '1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    to_cnt <= '0;
                    grant  <= PORT_NONE;
                end
                default: ;
            endcase
        end
    end

    // Strobes and acks decode straight from state so reset kills them without waiting for a clock
    assign bus.mem_cs_o   = (state == WAIT);
    assign bus.mem_oe_o   = (state == WAIT) & ~lat_we;
    assign bus.mem_we_o   = (state == WAIT) &  lat_we;
    assign bus.mem_addr_o = lat_addr;
    assign bus.mem_data_o = lat_wdata;

    assign bus.vid_ack_o  = (state == DONE) && (grant == PORT_VID);
    assign bus.cpu_ack_o  = (state == DONE) && (grant == PORT_CPU);
    assign bus.ioc_ack_o  = (state == DONE) && (grant == PORT_IOC);

    assign bus.rdata_o    = rdata;
    assign bus.err_o      = err;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: vector table of single transactions plus
// hand sequences for priority, starvation, download masking, timeout and async reset.
module tb_sdram_port_arbiter;
    import sdram_arb_pkg::*;

    localparam int AW = 25;
    localparam int DW = 8;

    logic clk_sys = 1'b0;
    logic rst;
    always #5 clk_sys = ~clk_sys;

    sdram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    sdram_port_arbiter #(
        .AW(AW), .DW(DW), .STARVE(16), .TIMEOUT(255)
    ) dut (
        .clock_i (clk_sys),
        .reset_i (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        port_t         port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rd;
        int            dly;
        logic          exp_oe;
        logic          exp_we;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic clear_inputs();
        bus.dl_active_i = 0;
        bus.vid_req_i = 0; bus.vid_addr_i = '0;
        bus.cpu_req_i = 0; bus.cpu_we_i = 0; bus.cpu_addr_i = '0; bus.cpu_wdata_i = '0;
        bus.ioc_req_i = 0; bus.ioc_addr_i = '0; bus.ioc_wdata_i = '0;
        bus.mem_data_i = '0; bus.mem_done_i = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic set_req(input port_t p, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd);
        case (p)
            PORT_VID: begin bus.vid_req_i = 1; bus.vid_addr_i = addr; end
            PORT_CPU: begin
                bus.cpu_req_i = 1; bus.cpu_we_i = we;
                bus.cpu_addr_i = addr; bus.cpu_wdata_i = wd;
            end
            PORT_IOC: begin bus.ioc_req_i = 1; bus.ioc_addr_i = addr; bus.ioc_wdata_i = wd; end
            default: ;
        endcase
    endtask

    task automatic drop_req(input port_t p);
        case (p)
            PORT_VID: bus.vid_req_i = 0;
            PORT_CPU: bus.cpu_req_i = 0;
            PORT_IOC: bus.ioc_req_i = 0;
            default: ;
        endcase
    endtask

    function automatic port_t ack_port();
        int n;
        n = int'(bus.vid_ack_o) + int'(bus.cpu_ack_o) + int'(bus.ioc_ack_o);
        if (n != 1) return PORT_NONE;
        if (bus.vid_ack_o) return PORT_VID;
        if (bus.cpu_ack_o) return PORT_CPU;
        return PORT_IOC;
    endfunction

    task automatic chk_quiet(input string name);
        chk({name, "_cs"}, bus.mem_cs_o, 0);
        chk({name, "_oe"}, bus.mem_oe_o, 0);
        chk({name, "_we"}, bus.mem_we_o, 0);
        chk({name, "_acks"}, {bus.vid_ack_o, bus.cpu_ack_o, bus.ioc_ack_o}, 0);
    endtask

    // Waits (bounded) for strobes, completes the transaction with rd, returns in the ack cycle
    task automatic serve(input logic [DW-1:0] rd, output port_t who, output logic we,
                         output logic [DW-1:0] wd, output bit ok);
        ok = 0; who = PORT_NONE; we = 0; wd = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.mem_cs_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            chk("serve_grant_seen", 0, 1);
            return;
        end
        we = bus.mem_we_o;
        wd = bus.mem_data_o;
        bus.mem_done_i = 1;
        bus.mem_data_i = rd;
        tick();
        bus.mem_done_i = 0;
        who = ack_port();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        port_t         who;
        logic          we;
        logic [DW-1:0] wd;
        bit            ok;
        port_t         order[3];
        int            n_vid;
        bit            got;
        int            cycles;
        int            cs_cycles;

        tbl[0] = '{PORT_CPU, 1'b0, 25'h0000123, 8'h00, 8'hA5, 5, 1'b1, 1'b0, 8'hA5};
        tbl[1] = '{PORT_CPU, 1'b1, 25'h1ABCDE0, 8'h3C, 8'h77, 2, 1'b0, 1'b1, 8'hA5};
        tbl[2] = '{PORT_VID, 1'b0, 25'h00000FF, 8'h00, 8'h5A, 1, 1'b1, 1'b0, 8'h5A};
        tbl[3] = '{PORT_IOC, 1'b1, 25'h1FFFFFF, 8'hC3, 8'h00, 3, 1'b0, 1'b1, 8'h5A};
        tbl[4] = '{PORT_VID, 1'b0, 25'h0000000, 8'h00, 8'h00, 4, 1'b1, 1'b0, 8'h00};

        clear_inputs();
        rst = 1'b1;
        #2;
        chk_quiet("in_reset");
        tick();
        rst = 1'b0;
        tick();
        chk_quiet("after_reset");
        chk("after_reset_rdata", bus.rdata_o, 0);
        chk("after_reset_err", bus.err_o, 0);
        chk("after_reset_addr", bus.mem_addr_o, 0);

        // Single transactions from the table
        foreach (tbl[k]) begin
            set_req(tbl[k].port, tbl[k].we, tbl[k].addr, tbl[k].wdata);
            tick();
            chk($sformatf("v%0d_cs", k), bus.mem_cs_o, 1);
            chk($sformatf("v%0d_oe", k), bus.mem_oe_o, tbl[k].exp_oe);
            chk($sformatf("v%0d_we", k), bus.mem_we_o, tbl[k].exp_we);
            chk($sformatf("v%0d_addr", k), bus.mem_addr_o, tbl[k].addr);
            if (tbl[k].exp_we) chk($sformatf("v%0d_wdata", k), bus.mem_data_o, tbl[k].wdata);
            repeat (tbl[k].dly - 1) tick();
            chk($sformatf("v%0d_cs_before_done", k), bus.mem_cs_o, 1);
            bus.mem_done_i = 1;
            bus.mem_data_i = tbl[k].rd;
            tick();
            bus.mem_done_i = 0;
            chk($sformatf("v%0d_ack", k), ack_port(), tbl[k].port);
            chk($sformatf("v%0d_rdata", k), bus.rdata_o, tbl[k].exp_rdata);
            chk($sformatf("v%0d_cs_low", k), bus.mem_cs_o, 0);
            drop_req(tbl[k].port);
            tick();
        end

        // All three requesting together
        order[0] = PORT_VID; order[1] = PORT_CPU; order[2] = PORT_IOC;
        set_req(PORT_VID, 1'b0, 25'h10, 8'h00);
        set_req(PORT_CPU, 1'b0, 25'h20, 8'h00);
        set_req(PORT_IOC, 1'b1, 25'h30, 8'hE7);
        for (int k = 0; k < 3; k++) begin
            serve(8'h11, who, we, wd, ok);
            chk($sformatf("all3_order%0d", k), who, order[k]);
            chk($sformatf("all3_we%0d", k), we, (k == 2) ? 1 : 0);
            if (k == 2) chk("all3_ioc_data", wd, 8'hE7);
            drop_req(order[k]);
        end
        tick();

        // Starvation: video never lets go, ioctl pending
        do_reset();
        set_req(PORT_VID, 1'b0, 25'h40, 8'h00);
        set_req(PORT_IOC, 1'b1, 25'h50, 8'h66);
        n_vid = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            serve(8'h22, who, we, wd, ok);
            if (!ok) break;
            if (who == PORT_VID) n_vid++;
            else if (who == PORT_IOC) begin
                got = 1;
                bus.ioc_req_i = 0;
            end else chk("starve_who", who, PORT_VID);
        end
        chk("starve_ioc_won", got, 1);
        chk("starve_vid_grants", n_vid, 16);
        chk("starve_cnt_cleared", dut.starve_cnt, 0);
        bus.vid_req_i = 0;
        tick();
        tick();

        // Download active masks the CPU
        do_reset();
        bus.dl_active_i = 1;
        set_req(PORT_CPU, 1'b0, 25'h456, 8'h00);
        set_req(PORT_IOC, 1'b1, 25'h789, 8'h12);
        for (int k = 0; k < 3; k++) begin
            serve(8'h33, who, we, wd, ok);
            chk($sformatf("dl_ioc%0d", k), who, PORT_IOC);
        end
        bus.dl_active_i = 0;
        serve(8'h44, who, we, wd, ok);
        chk("dl_cpu_after_fall", who, PORT_CPU);
        chk("dl_cpu_rdata", bus.rdata_o, 8'h44);
        drop_req(PORT_CPU);
        drop_req(PORT_IOC);
        tick();

        // Timeout on a CPU read
        set_req(PORT_CPU, 1'b0, 25'h777, 8'h00);
        cycles = 0;
        cs_cycles = 0;
        got = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            cycles++;
            if (bus.mem_cs_o) cs_cycles++;
            if (bus.cpu_ack_o) begin
                got = 1;
                break;
            end
        end
        chk("to_ack_seen", got, 1);
        chk("to_ack_cycle", cycles, 256);
        chk("to_wait_cycles", cs_cycles, 255);
        chk("to_rdata", bus.rdata_o, 8'hFF);
        chk("to_err", bus.err_o, 1);
        chk("to_cs_low", bus.mem_cs_o, 0);
        drop_req(PORT_CPU);
        tick();
        tick();
        chk("to_err_sticky", bus.err_o, 1);

        // Stray mem_done in IDLE
        bus.mem_done_i = 1;
        bus.mem_data_i = 8'h42;
        tick();
        bus.mem_done_i = 0;
        chk_quiet("stray_done");
        chk("stray_done_rdata", bus.rdata_o, 8'hFF);
        tick();
        chk("stray_done_acks2", {bus.vid_ack_o, bus.cpu_ack_o, bus.ioc_ack_o}, 0);

        // Reset in the middle of WAIT
        set_req(PORT_CPU, 1'b0, 25'h999, 8'h00);
        tick();
        chk("rst_mid_cs_before", bus.mem_cs_o, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_quiet("rst_mid_async");
        drop_req(PORT_CPU);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet($sformatf("rst_release%0d", i));
        end
        chk("rst_err_cleared", bus.err_o, 0);
        chk("rst_rdata_cleared", bus.rdata_o, 0);
        set_req(PORT_VID, 1'b0, 25'h2468, 8'h00);
        serve(8'h9C, who, we, wd, ok);
        chk("rst_fresh_ack", who, PORT_VID);
        chk("rst_fresh_rdata", bus.rdata_o, 8'h9C);
        drop_req(PORT_VID);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
